ddr5_cmd_queue: RTL and testbench
=================================

# ddr5_cmd_queue

Parametrised, synthesizable DDR5 request queue with an integrated head-of-queue command sequencer for the memory scheduler. It accepts CPU-side requests (core, operation, byte address), decodes each address into DDR5 bank group/bank/row/column fields, and buffers the requests in FIFO order. It then issues a closed-page command stream (ACT0, ACT1, RD0/RD1 or WR0/WR1, PRE) for the oldest request, spacing commands by parametrised DRAM timing gaps. It sits between the trace-driven request source and the DRAM command output logger.

## Interface
Parameters:
- DEPTH, 16: queue entries (≥2, power of two not required)
- ADDR_W, 34: request byte-address width
- CORE_W, 4: core-ID width
- AF_THRESH, 12: almost_full asserted when occupancy ≥ AF_THRESH
- T_RCD, 39: cycles from ACT0 issue to RD0/WR0 issue (≥2)
- T_CL, 40 / T_CWL, 38: read / write latency
- T_BURST, 8: burst duration
- T_WR, 48: write recovery
- T_RP, 39: cycles from PRE issue to next ACT0 issue (≥1)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  queue can accept (registered; = occupancy < DEPTH)
- req_core  in  CORE_W  issuing core
- req_op  in  2  0 = data read, 1 = write, 2 = instruction fetch (read), 3 = illegal
- req_addr  in  ADDR_W  byte address
- cmd_valid  out  1  command present this cycle
- cmd_code  out  3  ACT0=0, ACT1=1, RD0=2, RD1=3, WR0=4, WR1=5, PRE=6, NOP=7
- cmd_bg  out  3, cmd_bank  out  2, cmd_row  out  16, cmd_col  out  10  decoded target
- cmd_core  out  CORE_W  core of the head request
- done_valid  out  1  one-cycle pulse when the head request retires
- occupancy  out  $clog2(DEPTH+1)  valid entries
- almost_full  out  1  occupancy ≥ AF_THRESH
- drop_count  out  16  illegal-op requests discarded (saturating)

## Operation
- Address decode at enqueue: col_lo = addr[5:2], channel = addr[6] (ignored), bg = addr[9:7], bank = addr[11:10], col_hi = addr[17:12], row = addr[33:18], column = {col_hi, col_lo}. The byte select addr[1:0] is dropped.
- Enqueue: on req_valid & req_ready with req_op ≠ 3, write {core, is_write, bg, bank, row, col} at the tail. When req_op = 3, the handshake completes (the request is consumed), nothing is stored, and drop_count increments, saturating at 16'hFFFF.
- Circular buffer, with head/tail pointers wrapping at DEPTH-1 → 0.
- Sequencer FSM, one command per cycle at most:
  - IDLE: if occupancy > 0 → ACT0.
  - ACT0 → ACT1 (next cycle).
  - ACT1 → WAIT_RCD.
  - WAIT_RCD: count until T_RCD cycles have elapsed since ACT0 → RW0.
  - RW0 (RD0 or WR0 per entry) → RW1 (RD1 or WR1; the column is presented on both halves).
  - RW1 → WAIT_DATA.
  - WAIT_DATA: wait until T_CL+T_BURST (read) or T_CWL+T_BURST+T_WR (write) cycles have elapsed since RW0 → PRE.
  - PRE: issue PRE, pop head, pulse done_valid → WAIT_RP.
  - WAIT_RP: wait until T_RP cycles have elapsed since PRE → IDLE, or directly to ACT0 in the same cycle if entries remain.
- cmd_valid = 1 only in the ACT0, ACT1, RW0, RW1 and PRE states. Otherwise cmd_code = NOP and the field outputs hold their last values.
- Closed-page policy only; no reordering and no refresh.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): head = tail = 0, occupancy = 0, req_ready = 1, almost_full = 0, cmd_valid = 0, cmd_code = NOP, all cmd fields = 0, done_valid = 0, drop_count = 0, FSM = IDLE. Reset mid-sequence abandons the request with no PRE issued.
- Enqueue-to-ACT0 latency: an entry pushed at edge N into an empty, idle queue produces ACT0 at cycle N+1.
- Push and pop in the same cycle: occupancy is unchanged and both succeed.
- When full, req_ready = 0 even if a pop occurs that cycle; no bypass. req_ready rises the cycle after the pop.
- An empty queue never issues commands. Popping (PRE) only occurs when occupancy ≥ 1 by construction.
- Back-to-back requests: the next ACT0 is exactly T_RP cycles after PRE.
- occupancy and almost_full are registered and updated the edge after the handshake.

## Test plan
- Bench parameters: T_RCD=4, T_CL=5, T_CWL=4, T_BURST=2, T_WR=3, T_RP=3, DEPTH=4, AF_THRESH=3.
- Reset then a single read at addr 34'h0_0003_2A84 → bg=5, bank=2, row=0, col={6'h32, 4'h1}. Required command sequence: ACT0@1, ACT1@2, RD0@5, RD1@6, PRE@12, done_valid@12, occupancy back to 0.
- Single write at the same address: WR0@5, PRE = WR0 + 9 (@14), done_valid coincident with PRE.
- Push 5 requests back-to-back with no pops: 4 are accepted, req_ready = 0 after the 4th, almost_full = 1 from occupancy 3. After the first PRE, req_ready returns the next cycle and the 5th request is accepted.
- Two queued reads: the second ACT0 occurs exactly 3 cycles after the first PRE, in FIFO order, and cmd_core matches each request's core.
- Request with req_op = 3: accepted with no queue entry, drop_count = 1, no commands issued.
- Assert reset_n = 0 during WAIT_DATA: all outputs return to reset values immediately. After release, a new request starts a fresh ACT0 and no stale PRE is issued.

Source files
------------

// File: rtl/ddr5_cmd_queue.sv
// DDR5 request FIFO with a closed-page command sequencer for the head entry.
// Addresses are decoded to bg/bank/row/col at enqueue; the oldest entry is walked through ACT/RW/PRE.
module ddr5_cmd_queue #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 34,
    parameter int CORE_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int T_RCD     = 39,
    parameter int T_CL      = 40,
    parameter int T_CWL     = 38,
    parameter int T_BURST   = 8,
    parameter int T_WR      = 48,
    parameter int T_RP      = 39
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [CORE_W-1:0]            req_core,
    input  logic [1:0]                   req_op,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         cmd_valid,
    output logic [2:0]                   cmd_code,
    output logic [2:0]                   cmd_bg,
    output logic [1:0]                   cmd_bank,
    output logic [15:0]                  cmd_row,
    output logic [9:0]                   cmd_col,
    output logic [CORE_W-1:0]            cmd_core,
    output logic                         done_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         almost_full,
    output logic [15:0]                  drop_count
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [15:0] RCD_LIM = 16'(T_RCD - 1);
    localparam logic [15:0] RD_LIM  = 16'(T_CL + T_BURST - 1);
    localparam logic [15:0] WR_LIM  = 16'(T_CWL + T_BURST + T_WR - 1);
    localparam logic [15:0] RP_LIM  = 16'(T_RP - 1);

    typedef enum logic [2:0] {
        C_ACT0 = 3'd0, C_ACT1 = 3'd1, C_RD0 = 3'd2, C_RD1 = 3'd3,
        C_WR0  = 3'd4, C_WR1  = 3'd5, C_PRE = 3'd6, C_NOP = 3'd7
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_RW0, S_RW1, S_WAIT_DATA, S_PRE, S_WAIT_RP
    } state_e;

    typedef struct packed {
        logic [CORE_W-1:0] core;
        logic              wr;
        logic [2:0]        bg;
        logic [1:0]        bank;
        logic [15:0]       row;
        logic [9:0]        col;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head, tail, head_inc, tail_inc;
    logic [OCC_W-1:0] occ_nxt;
    logic             accept, push, pop;
    state_e           state;
    logic [15:0]      cnt;
    logic             cur_wr;
    logic             start_act;
    entry_t           act_ent;
    logic             rcd_done, data_done, rp_done;
    logic             unused_addr;

    assign unused_addr = ^req_addr;

    assign accept   = req_valid & req_ready;
    assign push     = accept & (req_op != 2'd3);
    assign pop      = (state == S_PRE);
    assign head_inc = (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign tail_inc = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;

    always_comb begin
        occ_nxt = occupancy;
        if (push && !pop)
            occ_nxt = occupancy + 1'b1;
        else if (pop && !push)
            occ_nxt = occupancy - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[tail] <= '{core: req_core, wr: (req_op == 2'd1), bg: req_addr[9:7],
                           bank: req_addr[11:10], row: req_addr[33:18],
                           col: {req_addr[17:12], req_addr[5:2]}};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head        <= '0;
            tail        <= '0;
            occupancy   <= '0;
            req_ready   <= 1'b1;
            almost_full <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push)
                tail <= tail_inc;
            if (pop)
                head <= head_inc;
            occupancy   <= occ_nxt;
            req_ready   <= int'(occ_nxt) < DEPTH;
            almost_full <= int'(occ_nxt) >= AF_THRESH;
            if (accept && (req_op == 2'd3) && (drop_count != '1))
                drop_count <= drop_count + 16'd1;
        end
    end

    // cnt holds the cycles elapsed since the last anchor command (ACT0, RW0 or PRE) was shown.
    assign rcd_done  = (cnt >= RCD_LIM);
    assign data_done = (cnt >= (cur_wr ? WR_LIM : RD_LIM));
    assign rp_done   = (cnt >= RP_LIM);

    // During PRE the head has not advanced yet, so an immediate restart reads the next slot.
    always_comb begin
        start_act = 1'b0;
        act_ent   = mem[head];
        case (state)
            S_IDLE:    start_act = (occupancy != '0);
            S_WAIT_RP: start_act = rp_done && (occupancy != '0);
            S_PRE: begin
                start_act = rp_done && (occupancy > OCC_W'(1));
                act_ent   = mem[head_inc];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cur_wr     <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= C_NOP;
            done_valid <= 1'b0;
            cmd_bg     <= '0;
            cmd_bank   <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            cmd_core   <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            cmd_code   <= C_NOP;
            done_valid <= 1'b0;
            cnt        <= cnt + 16'd1;
            if (start_act) begin
                state     <= S_ACT0;
                cmd_valid <= 1'b1;
                cmd_code  <= C_ACT0;
                cnt       <= '0;
                cur_wr    <= act_ent.wr;
                cmd_bg    <= act_ent.bg;
                cmd_bank  <= act_ent.bank;
                cmd_row   <= act_ent.row;
                cmd_col   <= act_ent.col;
                cmd_core  <= act_ent.core;
            end else begin
                case (state)
                    S_ACT0: begin
                        state     <= S_ACT1;
                        cmd_valid <= 1'b1;
                        cmd_code  <= C_ACT1;
                    end
                    S_ACT1, S_WAIT_RCD: begin
                        if (rcd_done) begin
                            state     <= S_RW0;
                            cmd_valid <= 1'b1;
                            cmd_code  <= cur_wr ? C_WR0 : C_RD0;
                            cnt       <= '0;
                        end else begin
                            state <= S_WAIT_RCD;
                        end
                    end
                    S_RW0: begin
                        state     <= S_RW1;
                        cmd_valid <= 1'b1;
                        cmd_code  <= cur_wr ? C_WR1 : C_RD1;
                    end
                    S_RW1, S_WAIT_DATA: begin
                        if (data_done) begin
                            state      <= S_PRE;
                            cmd_valid  <= 1'b1;
                            cmd_code   <= C_PRE;
                            done_valid <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            state <= S_WAIT_DATA;
                        end
                    end
                    S_PRE:     state <= rp_done ? S_IDLE : S_WAIT_RP;
                    S_WAIT_RP: if (rp_done) state <= S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ddr5_cmd_queue.sv
// Directed bench for ddr5_cmd_queue with short DRAM timings and a 4-entry queue.
// Cycle k is the interval after the k-th rising edge counted from the request's enqueue edge.
module tb_ddr5_cmd_queue;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_core;
    logic [1:0]  req_op;
    logic [33:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [3:0]  cmd_core;
    logic        done_valid;
    logic [2:0]  occupancy;
    logic        almost_full;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    ddr5_cmd_queue #(
        .DEPTH(4), .ADDR_W(34), .CORE_W(4), .AF_THRESH(3),
        .T_RCD(4), .T_CL(5), .T_CWL(4), .T_BURST(2), .T_WR(3), .T_RP(3)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_core(req_core),
        .req_op(req_op), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_core(cmd_core),
        .done_valid(done_valid), .occupancy(occupancy), .almost_full(almost_full),
        .drop_count(drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [3:0] core, input logic [1:0] op, input logic [33:0] addr);
        req_valid = 1'b1;
        req_core  = core;
        req_op    = op;
        req_addr  = addr;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        cyc = 0;
    endtask

    // Expected command for one request: ACT0@a, ACT1@a+1, RW0@r, RW1@r+1, PRE@p; a<0 means none.
    function automatic logic [2:0] exp_code(input int c, input int a, input int r, input int p, input bit w);
        if (a < 0)      return 3'd7;
        if (c == a)     return 3'd0;
        if (c == a + 1) return 3'd1;
        if (c == r)     return w ? 3'd4 : 3'd2;
        if (c == r + 1) return w ? 3'd5 : 3'd3;
        if (c == p)     return 3'd6;
        return 3'd7;
    endfunction

    task automatic walk(input string tag, input int a1, input int r1, input int p1, input bit w1,
                        input int a2, input int r2, input int p2, input bit w2, input int last);
        logic [2:0] ec;
        while (cyc < last) begin
            tick();
            ec = exp_code(cyc, a1, r1, p1, w1);
            if (ec == 3'd7)
                ec = exp_code(cyc, a2, r2, p2, w2);
            check($sformatf("%s_code@%0d", tag, cyc), cmd_code, ec);
            check($sformatf("%s_valid@%0d", tag, cyc), cmd_valid, ec != 3'd7);
            check($sformatf("%s_done@%0d", tag, cyc), done_valid,
                  (a1 >= 0 && cyc == p1) || (a2 >= 0 && cyc == p2));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_occ"}, occupancy, 3'd0);
        check({tag, "_af"}, almost_full, 1'b0);
        check({tag, "_cvalid"}, cmd_valid, 1'b0);
        check({tag, "_ccode"}, cmd_code, 3'd7);
        check({tag, "_fields"}, {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core}, 37'd0);
        check({tag, "_done"}, done_valid, 1'b0);
        check({tag, "_drop"}, drop_count, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [33:0] addr_a, addr_b, addr_f;
        addr_a = 34'h0_0003_2A84;
        addr_b = {16'hABCD, 6'h15, 2'd1, 3'd3, 1'b1, 4'hA, 2'b11};
        addr_f = {16'h8001, 6'h3F, 2'd3, 3'd7, 1'b1, 4'hF, 2'b10};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_core  = '0;
        req_op    = '0;
        req_addr  = '0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("rst");
        #2 reset_n = 1'b1;
        tick();
        check("rst_rel_code", cmd_code, 3'd7);

        // Single read: bg=5 bank=2 row=0 col=0x321
        push(4'h3, 2'd0, addr_a);
        check("rd_occ0", occupancy, 3'd1);
        check("rd_valid0", cmd_valid, 1'b0);
        walk("rd", 1, 5, 12, 1'b0, -1, 0, 0, 1'b0, 1);
        check("rd_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core},
              {3'd5, 2'd2, 16'h0000, 10'h321, 4'h3});
        walk("rd", 1, 5, 12, 1'b0, -1, 0, 0, 1'b0, 13);
        check("rd_occ13", occupancy, 3'd0);
        check("rd_ready13", req_ready, 1'b1);
        walk("rd", 1, 5, 12, 1'b0, -1, 0, 0, 1'b0, 16);

        // Single write at the same address: PRE = WR0 + 9
        push(4'h9, 2'd1, addr_a);
        walk("wr", 1, 5, 14, 1'b1, -1, 0, 0, 1'b0, 1);
        check("wr_core", cmd_core, 4'h9);
        walk("wr", 1, 5, 14, 1'b1, -1, 0, 0, 1'b0, 18);
        check("wr_occ", occupancy, 3'd0);

        // Illegal op is consumed and counted, never queued
        push(4'hC, 2'd3, addr_b);
        check("ill_drop", drop_count, 16'd1);
        check("ill_occ", occupancy, 3'd0);
        check("ill_ready", req_ready, 1'b1);
        walk("ill", -1, 0, 0, 1'b0, -1, 0, 0, 1'b0, 5);

        // Fill the queue: A..D accepted, E stalls until after the first PRE
        req_valid = 1'b1; req_core = 4'h1; req_op = 2'd0; req_addr = addr_a;
        @(posedge clock);
        #1;
        cyc = 0;
        check("full_occ0", occupancy, 3'd1);
        check("full_af0", almost_full, 1'b0);
        req_core = 4'h2; req_addr = addr_b;
        tick();
        check("full_occ1", occupancy, 3'd2);
        check("full_af1", almost_full, 1'b0);
        check("full_act0", cmd_code, 3'd0);
        check("full_core_a", cmd_core, 4'h1);
        req_core = 4'h3; req_op = 2'd1; req_addr = addr_f;
        tick();
        check("full_occ2", occupancy, 3'd3);
        check("full_af2", almost_full, 1'b1);
        check("full_ready2", req_ready, 1'b1);
        req_core = 4'h4; req_op = 2'd0; req_addr = addr_a;
        tick();
        check("full_occ3", occupancy, 3'd4);
        check("full_ready3", req_ready, 1'b0);
        req_core = 4'h5; req_addr = addr_f;
        walk("full", 1, 5, 12, 1'b0, 15, 19, 26, 1'b0, 12);
        check("full_ready12", req_ready, 1'b0);
        check("full_occ12", occupancy, 3'd4);
        walk("full", 1, 5, 12, 1'b0, 15, 19, 26, 1'b0, 13);
        check("full_ready13", req_ready, 1'b1);
        check("full_occ13", occupancy, 3'd3);
        walk("full", 1, 5, 12, 1'b0, 15, 19, 26, 1'b0, 14);
        req_valid = 1'b0;
        check("full_occ14", occupancy, 3'd4);
        check("full_ready14", req_ready, 1'b0);
        check("full_af14", almost_full, 1'b1);
        walk("full", 1, 5, 12, 1'b0, 15, 19, 26, 1'b0, 15);
        check("full_b_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core},
              {3'd3, 2'd1, 16'hABCD, 10'h15A, 4'h2});
        walk("full", 1, 5, 12, 1'b0, 15, 19, 26, 1'b0, 22);

        // Reset while B is in WAIT_DATA
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("mid");
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        cyc = 0;
        walk("post", -1, 0, 0, 1'b0, -1, 0, 0, 1'b0, 3);
        check("post_occ", occupancy, 3'd0);

        push(4'h7, 2'd2, addr_f);
        walk("fresh", 1, 5, 12, 1'b0, -1, 0, 0, 1'b0, 1);
        check("fresh_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core},
              {3'd7, 2'd3, 16'h8001, 10'h3FF, 4'h7});
        walk("fresh", 1, 5, 12, 1'b0, -1, 0, 0, 1'b0, 16);
        check("fresh_occ", occupancy, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
